lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- CPU-side load/store initiator for the RV32I core. It takes one load/store request per instruction (funct3 encoding, byte address, rs2 data) and drives a word-wide data-memory bus with byte strobes.
- Splits misaligned accesses into two word beats and returns sign- or zero-extended load data to writeback.
- Big-endian byte order: byte offset o maps to lane bits [31-8o -: 8]; mem_wstrb[i] enables bits [8i+7:8i], so offset o uses strobe bit 3-o.

Parameters:
- ADDR_W, 32, byte address width; upper address wraps modulo 2^ADDR_W.
- SPLIT_MISALIGNED, 1, 1 = split misaligned into two beats; 0 = misaligned returns resp_err with no bus access.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_dop  in  3  funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- req_addr  in  ADDR_W  byte address (ALU output).
- req_wdata  in  32  store data (rs2).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid; illegal dop or misaligned with SPLIT_MISALIGNED=0.
- mem_valid  out  1  bus beat request.
- mem_ready  in  1  bus accepts beat when mem_valid & mem_ready.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits always 0.
- mem_wstrb  out  4  byte strobes; 0000 on reads.
- mem_wdata  out  32  lane-aligned write data.
- mem_rvalid  in  1  read data valid, at least 1 cycle after read accept.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (async, rst=0):
  - State goes to IDLE.
  - All outputs 0 except req_ready=1 after release.
  - In-flight beat abandoned; no resp_valid is issued for it.
- States and transitions:
  - IDLE: req_valid & req_ready → capture request.
    - Illegal dop (store dop 3–7, load dop 3/6/7) → ERR.
    - Misaligned with SPLIT_MISALIGNED=0 → ERR.
    - Otherwise → B0.
  - B0: issue beat 0; hold mem_valid and all mem_* stable until mem_ready.
    - On accept: write → (split ? B1 : RESP); read → W0.
  - W0: wait mem_rvalid, latch mem_rdata → (split ? B1 : RESP).
  - B1: beat 1 at mem_addr = beat-0 address + 4 (wraps to 0 at the top).
    - On accept: write → RESP; read → W1.
  - W1: wait mem_rvalid, merge bytes → RESP.
  - RESP: resp_valid=1 for one cycle with rdata; → IDLE.
  - ERR: resp_valid=1, resp_err=1, rdata=0, no bus activity; → IDLE.
- Misalignment: half at offset 3; word at offset 1, 2 or 3. Byte accesses never split.
- Strobes, beat 0: first byte offset o through offset 3. Beat 1: remaining bytes from offset 0.
  - Example: SW at offset 1 → beat0 strb 0111 carrying data[31:8], beat1 strb 1000 carrying data[7:0] in [31:24].
- Loads: gather bytes in address order (lowest address = MSB), then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Latency, aligned, zero-wait bus:
  - Accept at cycle 0; mem_valid at cycle 1.
  - Store resp_valid at cycle 2.
  - Load resp_valid on the cycle after mem_rvalid.
- One outstanding transaction; mem_rvalid outside W0/W1 is ignored.
- mem_ready outside B0/B1 is ignored.

Decomposition:
- Package lsu_pkg:
  - funct3 constants DOP_B=0, DOP_H=1, DOP_W=2, DOP_BU=4, DOP_HU=5.
  - State encoding IDLE/B0/W0/B1/W1/RESP/ERR.
  - Byte-lane index function.
- One combinational sub-module, lsu_lane_align, which:
  - computes strobes, shifted write data and split flag from dop and offset;
  - merges two read words and sign-extends.

Test Plan:
- Aligned SW addr 0x100, data 0x11223344, mem_ready=1 → one beat: addr 0x100, strb 1111, wdata 0x11223344; resp_valid at cycle 2, err=0.
- LB addr 0x103, mem_rdata 0x000000F0 → read beat addr 0x100; resp_rdata 0xFFFFFFF0. Same access with LBU → 0x000000F0.
- LW addr 0x102, beat0 rdata 0xAABBCCDD, beat1 (addr 0x104) rdata 0xEEFF0011 → resp_rdata 0xCCDDEEFF.
- SH addr 0xFFFFFFFF, data 0x1234 → beat0 addr 0xFFFFFFFC, strb 0001, wdata[7:0]=0x12; beat1 addr 0x0, strb 1000, wdata[31:24]=0x34.
- req_dop=3 load → no mem_valid; resp_valid=1, resp_err=1, rdata 0 on cycle after accept. SPLIT_MISALIGNED=0 with LH addr 0x3 → same result.
- Reset asserted in W0 with mem_ready held 0, then release → mem_valid=0 and req_ready=1; no resp_valid; late mem_rvalid is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: funct3 codes, FSM states,
// big-endian lane mapping and request legality.
package lsu_pkg;

   localparam logic [2:0] DOP_B  = 3'd0;
   localparam logic [2:0] DOP_H  = 3'd1;
   localparam logic [2:0] DOP_W  = 3'd2;
   localparam logic [2:0] DOP_BU = 3'd4;
   localparam logic [2:0] DOP_HU = 3'd5;

   typedef enum logic [2:0] {
      S_IDLE, S_B0, S_W0, S_B1, S_W1, S_RESP, S_ERR
   } lsu_state_e;

   // Big-endian: byte offset o lives in strobe lane 3-o.
   function automatic logic [1:0] lane_idx(input logic [1:0] off);
      return 2'd3 - off;
   endfunction

   // Stores only have signed-size encodings; loads add the unsigned forms.
   function automatic logic dop_legal(input logic we, input logic [2:0] dop);
      if (we) return dop inside {DOP_B, DOP_H, DOP_W};
      return dop inside {DOP_B, DOP_H, DOP_W, DOP_BU, DOP_HU};
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: strobes and shifted write data for both
// beats, split detection, and read-word merge with sign/zero extension.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  dop,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword0,
   input  logic [31:0] rword1,
   output logic        split,
   output logic [3:0]  strb0,
   output logic [3:0]  strb1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic [31:0] rdata
);

   logic [7:0]         base;
   logic [7:0]         mask_off;
   logic [4:0]         rsh;
   logic [31:0]        dleft;
   logic [63:0]        wlane;
   logic [63:0]        rlane;
   logic [31:0]        rtop;
   logic signed [31:0] rsext;

   // Bytes are laid out across an 8-byte window spanning both beats,
   // lowest address first, so one shift handles aligned and split cases.
   always_comb begin
      case (dop[1:0])
         2'd0:    begin base = 8'h01; rsh = 5'd24; end
         2'd1:    begin base = 8'h03; rsh = 5'd16; end
         default: begin base = 8'h0F; rsh = 5'd0;  end
      endcase
      mask_off = base << off;
      split    = |mask_off[7:4];
      strb0    = '0;
      strb1    = '0;
      for (int k = 0; k < 4; k++) begin
         strb0[lane_idx(2'(k))] = mask_off[k];
         strb1[lane_idx(2'(k))] = mask_off[k+4];
      end
      dleft            = wdata << rsh;
      wlane            = {dleft, 32'h0} >> {off, 3'b000};
      {wdata0, wdata1} = wlane;
      rlane            = {rword0, rword1} << {off, 3'b000};
      rtop             = rlane[63:32];
      rsext            = $signed(rtop) >>> rsh;
      rdata            = dop[2] ? (rtop >> rsh) : rsext;
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// RV32I load/store initiator: one request at a time onto a word bus with
// byte strobes, misaligned accesses optionally split into two beats.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int ADDR_W           = 32,
   parameter bit SPLIT_MISALIGNED = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_dop,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        dop_q, dop_d;
   logic [1:0]        off_q, off_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic              mem_valid_q, mem_valid_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        mem_wstrb_q, mem_wstrb_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;

   logic              idle;
   logic [2:0]        a_dop;
   logic [1:0]        a_off;
   logic [31:0]       a_wdata, a_r0, a_r1;
   logic              a_split;
   logic [3:0]        a_strb0, a_strb1;
   logic [31:0]       a_wdata0, a_wdata1, a_rdata;
   logic [ADDR_W-1:0] addr_next;

   // In IDLE the aligner looks at the live request so the split/error
   // decision is made on the accept cycle; afterwards it sees the capture.
   assign idle      = (state_q == S_IDLE);
   assign a_dop     = idle ? req_dop        : dop_q;
   assign a_off     = idle ? req_addr[1:0]  : off_q;
   assign a_wdata   = idle ? req_wdata      : wdata_q;
   assign a_r0      = (state_q == S_W1) ? rbuf_q    : mem_rdata;
   assign a_r1      = (state_q == S_W1) ? mem_rdata : 32'h0;
   assign addr_next = addr_q + ADDR_W'(4);

   lsu_lane_align u_align (
      .dop    (a_dop),
      .off    (a_off),
      .wdata  (a_wdata),
      .rword0 (a_r0),
      .rword1 (a_r1),
      .split  (a_split),
      .strb0  (a_strb0),
      .strb1  (a_strb1),
      .wdata0 (a_wdata0),
      .wdata1 (a_wdata1),
      .rdata  (a_rdata)
   );

   // Next-state and registered-output computation for the beat sequencer.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      dop_d        = dop_q;
      off_d        = off_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      mem_valid_d  = mem_valid_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'h0;
      case (state_q)
         S_IDLE: if (req_valid) begin
            we_d    = req_we;
            dop_d   = req_dop;
            off_d   = req_addr[1:0];
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            wdata_d = req_wdata;
            if (!dop_legal(req_we, req_dop) || (a_split && !SPLIT_MISALIGNED)) begin
               state_d      = S_ERR;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
            end else begin
               state_d     = S_B0;
               mem_valid_d = 1'b1;
               mem_we_d    = req_we;
               mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
               mem_wstrb_d = req_we ? a_strb0  : 4'h0;
               mem_wdata_d = req_we ? a_wdata0 : 32'h0;
            end
         end
         S_B0: if (mem_ready) begin
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'h0;
            mem_wdata_d = 32'h0;
            if (!we_q) begin
               state_d = S_W0;
            end else if (a_split) begin
               state_d     = S_B1;
               mem_valid_d = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = addr_next;
               mem_wstrb_d = a_strb1;
               mem_wdata_d = a_wdata1;
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
            end
         end
         S_W0: if (mem_rvalid) begin
            if (a_split) begin
               rbuf_d      = mem_rdata;
               state_d     = S_B1;
               mem_valid_d = 1'b1;
               mem_addr_d  = addr_next;
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = a_rdata;
            end
         end
         S_B1: if (mem_ready) begin
            mem_valid_d = 1'b0;
            mem_we_d    = 1'b0;
            mem_wstrb_d = 4'h0;
            mem_wdata_d = 32'h0;
            if (we_q) begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
            end else begin
               state_d = S_W1;
            end
         end
         S_W1: if (mem_rvalid) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = a_rdata;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset drops any in-flight beat silently.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         dop_q        <= 3'd0;
         off_q        <= 2'd0;
         addr_q       <= '0;
         wdata_q      <= 32'h0;
         rbuf_q       <= 32'h0;
         mem_valid_q  <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wstrb_q  <= 4'h0;
         mem_wdata_q  <= 32'h0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         dop_q        <= dop_d;
         off_q        <= off_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         mem_valid_q  <= mem_valid_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign req_ready  = idle;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_valid  = mem_valid_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: table of single transactions driven
// through a small bus responder, plus reset and no-split error sequences.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0, req_valid_ns = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_dop = 3'd0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
   logic        mem_ready_ns = 1'b0, mem_rvalid_ns = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   logic        req_ready, resp_valid, resp_err, mem_valid, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        req_ready_ns, resp_valid_ns, resp_err_ns, mem_valid_ns, mem_we_ns;
   logic [31:0] resp_rdata_ns, mem_addr_ns, mem_wdata_ns;
   logic [3:0]  mem_wstrb_ns;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_dop(req_dop), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   lsu_mem_initiator #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_ns (
      .clk(clk), .rst(rst), .req_valid(req_valid_ns), .req_ready(req_ready_ns),
      .req_we(req_we), .req_dop(req_dop), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_ns), .resp_rdata(resp_rdata_ns), .resp_err(resp_err_ns),
      .mem_valid(mem_valid_ns), .mem_ready(mem_ready_ns), .mem_we(mem_we_ns),
      .mem_addr(mem_addr_ns), .mem_wstrb(mem_wstrb_ns), .mem_wdata(mem_wdata_ns),
      .mem_rvalid(mem_rvalid_ns), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  dop;
      logic [31:0] addr, wdata, rd0, rd1;
      logic        err;
      int          beats, stall, lat;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] w0, a1;
      logic [3:0]  s1;
      logic [31:0] w1, rdata;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   // Present one request, act as the bus, and check beats and the response.
   task automatic run(input vec_t v, input int id);
      int          beats = 0, cyc = 0, stl = 0;
      bit          done = 1'b0, rdp = 1'b0;
      logic [31:0] rdw = 32'h0;
      chk($sformatf("v%0d req_ready", id), 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = v.we; req_dop = v.dop;
      req_addr = v.addr; req_wdata = v.wdata;
      @(negedge clk);
      req_valid = 1'b0;
      while (!done && cyc < 40) begin
         if (resp_valid) begin
            done = 1'b1;
            chk($sformatf("v%0d latency", id), 32'(cyc), 32'(v.lat));
            chk($sformatf("v%0d resp_err", id), 32'(resp_err), 32'(v.err));
            chk($sformatf("v%0d resp_rdata", id), resp_rdata, v.rdata);
         end else if (mem_valid) begin
            chk($sformatf("v%0d b%0d we", id, beats), 32'(mem_we), 32'(v.we));
            chk($sformatf("v%0d b%0d addr", id, beats), mem_addr, (beats == 0) ? v.a0 : v.a1);
            chk($sformatf("v%0d b%0d strb", id, beats), 32'(mem_wstrb), 32'((beats == 0) ? v.s0 : v.s1));
            chk($sformatf("v%0d b%0d wdata", id, beats), mem_wdata, (beats == 0) ? v.w0 : v.w1);
            if (beats == 0 && stl < v.stall) begin
               stl++;
            end else begin
               mem_ready = 1'b1;
               rdp       = !mem_we;
               rdw       = (beats == 0) ? v.rd0 : v.rd1;
               beats++;
            end
         end
         @(negedge clk);
         mem_ready  = 1'b0;
         mem_rvalid = 1'b0;
         if (rdp) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdw;
            rdp        = 1'b0;
         end
         cyc++;
      end
      chk($sformatf("v%0d completed", id), 32'(done), 32'd1);
      chk($sformatf("v%0d beats", id), 32'(beats), 32'(v.beats));
      chk($sformatf("v%0d resp pulse", id), 32'(resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //        we dop addr          wdata         rd0           rd1           err bt st lat a0            s0    w0            a1            s1    w1            rdata
      vt[0]  = '{1, 2, 32'h00000100, 32'h11223344, 32'h0,        32'h0,        0, 1, 0, 1, 32'h00000100, 4'hF, 32'h11223344, 32'h0,        4'h0, 32'h0,        32'h0};
      vt[1]  = '{0, 0, 32'h00000103, 32'h0,        32'h000000F0, 32'h0,        0, 1, 0, 2, 32'h00000100, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFFFFF0};
      vt[2]  = '{0, 4, 32'h00000103, 32'h0,        32'h000000F0, 32'h0,        0, 1, 0, 2, 32'h00000100, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h000000F0};
      vt[3]  = '{0, 2, 32'h00000102, 32'h0,        32'hAABBCCDD, 32'hEEFF0011, 0, 2, 0, 4, 32'h00000100, 4'h0, 32'h0,        32'h00000104, 4'h0, 32'h0,        32'hCCDDEEFF};
      vt[4]  = '{1, 1, 32'hFFFFFFFF, 32'h00001234, 32'h0,        32'h0,        0, 2, 0, 2, 32'hFFFFFFFC, 4'h1, 32'h00000012, 32'h00000000, 4'h8, 32'h34000000, 32'h0};
      vt[5]  = '{0, 3, 32'h00000200, 32'h0,        32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0};
      vt[6]  = '{1, 2, 32'h00000101, 32'hA1B2C3D4, 32'h0,        32'h0,        0, 2, 2, 4, 32'h00000100, 4'h7, 32'h00A1B2C3, 32'h00000104, 4'h8, 32'hD4000000, 32'h0};
      vt[7]  = '{0, 1, 32'h00000102, 32'h0,        32'h12348765, 32'h0,        0, 1, 0, 2, 32'h00000100, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hFFFF8765};
      vt[8]  = '{0, 5, 32'h00000100, 32'h0,        32'h8765ABCD, 32'h0,        0, 1, 0, 2, 32'h00000100, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h00008765};
      vt[9]  = '{1, 0, 32'h00000102, 32'hFFFFFFAB, 32'h0,        32'h0,        0, 1, 0, 1, 32'h00000100, 4'h2, 32'h0000AB00, 32'h0,        4'h0, 32'h0,        32'h0};
      vt[10] = '{1, 4, 32'h00000100, 32'h12345678, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'h0};
      vt[11] = '{0, 2, 32'h00000300, 32'h0,        32'hDEADBEEF, 32'h0,        0, 1, 0, 2, 32'h00000300, 4'h0, 32'h0,        32'h0,        4'h0, 32'h0,        32'hDEADBEEF};
      vt[12] = '{0, 1, 32'h000001FF, 32'h0,        32'h000000A5, 32'h5A000000, 0, 2, 0, 4, 32'h000001FC, 4'h0, 32'h0,        32'h00000200, 4'h0, 32'h0,        32'hFFFFA55A};
      vt[13] = '{1, 2, 32'h00000103, 32'h01020304, 32'h0,        32'h0,        0, 2, 0, 2, 32'h00000100, 4'h1, 32'h00000001, 32'h00000104, 4'hE, 32'h02030400, 32'h0};

      // reset state, during and after reset
      repeat (2) @(negedge clk);
      chk("rst mem_valid", 32'(mem_valid), 32'd0);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wstrb", 32'(mem_wstrb), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("post-rst req_ready", 32'(req_ready), 32'd1);
      chk("post-rst resp_rdata", resp_rdata, 32'h0);
      chk("post-rst mem_we", 32'(mem_we), 32'd0);

      for (int i = 0; i < 14; i++) run(vt[i], i);

      // reset while waiting for read data; the late data must be dropped
      req_valid = 1'b1; req_we = 1'b0; req_dop = 3'd2; req_addr = 32'h400;
      @(negedge clk);
      req_valid = 1'b0;
      chk("w0rst beat0 valid", 32'(mem_valid), 32'd1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      chk("w0rst in W0 mem_valid", 32'(mem_valid), 32'd0);
      chk("w0rst in W0 req_ready", 32'(req_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("w0rst async mem_valid", 32'(mem_valid), 32'd0);
      chk("w0rst async req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h55667788;
      @(negedge clk);
      mem_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("w0rst idle%0d resp_valid", i), 32'(resp_valid), 32'd0);
         chk($sformatf("w0rst idle%0d mem_valid", i), 32'(mem_valid), 32'd0);
         chk($sformatf("w0rst idle%0d req_ready", i), 32'(req_ready), 32'd1);
         @(negedge clk);
      end
      run(vt[11], 99);

      // no-split build: misaligned halfword is rejected without bus traffic
      req_valid_ns = 1'b1; req_we = 1'b0; req_dop = 3'd1; req_addr = 32'h3;
      @(negedge clk);
      req_valid_ns = 1'b0;
      chk("ns resp_valid", 32'(resp_valid_ns), 32'd1);
      chk("ns resp_err", 32'(resp_err_ns), 32'd1);
      chk("ns resp_rdata", resp_rdata_ns, 32'h0);
      chk("ns mem_valid", 32'(mem_valid_ns), 32'd0);
      @(negedge clk);
      chk("ns resp pulse", 32'(resp_valid_ns), 32'd0);
      chk("ns req_ready", 32'(req_ready_ns), 32'd1);
      chk("ns mem_valid after", 32'(mem_valid_ns), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
